// File: rtl/lbp_pkg.sv
// Shared encodings for the LBP stream engine: operating modes, neighbour bit
// positions, the non-uniform code value and the control state encoding.
package lbp_pkg;

    typedef enum logic [1:0] {
        LBP_MODE_BASIC   = 2'd0,
        LBP_MODE_THRESH  = 2'd1,
        LBP_MODE_UNIFORM = 2'd2,
        LBP_MODE_RSVD    = 2'd3
    } lbp_mode_e;

    // Bit k of an LBP code is the comparison result for neighbour k.
    localparam int NB_TL = 0;
    localparam int NB_T  = 1;
    localparam int NB_TR = 2;
    localparam int NB_L  = 3;
    localparam int NB_R  = 4;
    localparam int NB_BL = 5;
    localparam int NB_B  = 6;
    localparam int NB_BR = 7;

    localparam logic [7:0] LBP_NONUNIFORM = 8'd9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } lbp_state_e;

endpackage

// File: rtl/lbp_line_buffer.sv
// Two-row line buffer: each accepted pixel is written into the newest row and
// the displaced value shifts into the older row at the same column.
module lbp_line_buffer
    import lbp_pkg::*;
#(
    parameter int IMG_W = 128,
    parameter int PIX_W = 8
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     wr_en_i,
    input  logic [((IMG_W > 1) ? $clog2(IMG_W) : 1)-1:0] wr_col_i,
    input  logic [((IMG_W > 1) ? $clog2(IMG_W) : 1)-1:0] rd_col_i,
    input  logic [PIX_W-1:0]                         pix_i,
    output logic [PIX_W-1:0]                         row1_o,
    output logic [PIX_W-1:0]                         row2_o
);
    logic [PIX_W-1:0] row1_mem [IMG_W];
    logic [PIX_W-1:0] row2_mem [IMG_W];
    logic [PIX_W-1:0] row1_q;
    logic [PIX_W-1:0] row2_q;

    // Storage is not cleared: a scored window only ever reads columns that
    // were written earlier in the same frame.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            row1_mem[wr_col_i] <= pix_i;
            row2_mem[wr_col_i] <= row1_q;
        end
    end

    // The read port is addressed with the column of the next accept, so the
    // registered data is ready exactly when that pixel arrives.
    always_ff @(posedge clk) begin
        if (reset) begin
            row1_q <= '0;
            row2_q <= '0;
        end else begin
            row1_q <= row1_mem[rd_col_i];
            row2_q <= row2_mem[rd_col_i];
        end
    end

    assign row1_o = row1_q;
    assign row2_o = row2_q;

endmodule

// File: rtl/lbp_stream_engine.sv
// Streaming 3x3 LBP engine: fetches each pixel once in raster order and emits
// one code per interior pixel in basic, thresholded or uniform-count mode.
module lbp_stream_engine
    import lbp_pkg::*;
#(
    parameter int IMG_W  = 128,
    parameter int IMG_H  = 128,
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [PIX_W-1:0]  lbp_thresh,
    input  logic              gray_ready,
    input  logic [PIX_W-1:0]  gray_data,
    output logic [ADDR_W-1:0] gray_addr,
    output logic              gray_req,
    output logic              lbp_valid,
    output logic [ADDR_W-1:0] lbp_addr,
    output logic [7:0]        lbp_data,
    output logic              finish
);
    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [COL_W-1:0]  LAST_COL = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(IMG_H - 1);
    localparam logic [ADDR_W-1:0] OUT_OFS  = ADDR_W'(IMG_W + 1);

    lbp_state_e        state_q, state_d;
    lbp_mode_e         mode_q;
    logic [PIX_W-1:0]  thresh_q;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              lbp_valid_q;
    logic [ADDR_W-1:0] lbp_addr_q;
    logic [7:0]        lbp_data_q;

    logic [PIX_W-1:0]  win_q [2][3];
    logic [PIX_W-1:0]  new_col [3];
    logic [PIX_W-1:0]  nb [8];
    logic [PIX_W-1:0]  centre;
    logic [PIX_W-1:0]  lb_row1, lb_row2;
    logic [7:0]        basic_bits, thresh_bits, code;
    logic              start_take, accept, last_col, last_row, win_full;

    function automatic logic [7:0] uniform_code(input logic [7:0] bits);
        logic [7:0] ring;
        logic [7:0] edges;
        logic [3:0] ones;
        logic [3:0] trans;
        // Circular walk TL,T,TR,R,BR,B,BL,L packed LSB first.
        ring  = {bits[NB_L], bits[NB_BL], bits[NB_B], bits[NB_BR],
                 bits[NB_R], bits[NB_TR], bits[NB_T], bits[NB_TL]};
        edges = ring ^ {ring[6:0], ring[7]};
        ones  = '0;
        trans = '0;
        for (int i = 0; i < 8; i++) begin
            ones  = ones + {3'b000, bits[i]};
            trans = trans + {3'b000, edges[i]};
        end
        return (trans <= 4'd2) ? {4'b0000, ones} : LBP_NONUNIFORM;
    endfunction

    assign start_take = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign accept     = (state_q == ST_FETCH) && gray_ready;
    assign last_col   = (col_q == LAST_COL);
    assign last_row   = (row_q == LAST_ROW);
    assign win_full   = (int'(row_q) >= 2) && (int'(col_q) >= 2);

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        addr_d  = addr_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_FETCH;
                    row_d   = '0;
                    col_d   = '0;
                    addr_d  = '0;
                end
            end
            ST_FETCH: begin
                if (accept) begin
                    if (last_col) begin
                        col_d = '0;
                        row_d = last_row ? '0 : row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                    if (last_col && last_row) begin
                        addr_d  = '0;
                        state_d = ST_DRAIN;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            row_q    <= '0;
            col_q    <= '0;
            addr_q   <= '0;
            mode_q   <= LBP_MODE_BASIC;
            thresh_q <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            addr_q  <= addr_d;
            if (start_take) begin
                mode_q   <= lbp_mode_e'(mode);
                thresh_q <= lbp_thresh;
            end
        end
    end

    lbp_line_buffer #(
        .IMG_W (IMG_W),
        .PIX_W (PIX_W)
    ) u_line_buf (
        .clk      (clk),
        .reset    (reset),
        .wr_en_i  (accept),
        .wr_col_i (col_q),
        .rd_col_i (col_d),
        .pix_i    (gray_data),
        .row1_o   (lb_row1),
        .row2_o   (lb_row2)
    );

    // Window holds columns c-2 and c-1; the incoming column completes it.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 3; k++) begin
                win_q[0][k] <= '0;
                win_q[1][k] <= '0;
            end
        end else if (accept) begin
            for (int k = 0; k < 3; k++) begin
                win_q[0][k] <= win_q[1][k];
                win_q[1][k] <= new_col[k];
            end
        end
    end

    always_comb begin
        new_col[0] = lb_row2;
        new_col[1] = lb_row1;
        new_col[2] = gray_data;
        nb[NB_TL]  = win_q[0][0];
        nb[NB_T]   = win_q[1][0];
        nb[NB_TR]  = new_col[0];
        nb[NB_L]   = win_q[0][1];
        nb[NB_R]   = new_col[1];
        nb[NB_BL]  = win_q[0][2];
        nb[NB_B]   = win_q[1][2];
        nb[NB_BR]  = new_col[2];
        centre     = win_q[1][1];
    end

    // The thresholded sum is one bit wider so a large offset saturates the test.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_cmp
            assign basic_bits[gi]  = (nb[gi] >= centre);
            assign thresh_bits[gi] = ({1'b0, nb[gi]} >= ({1'b0, centre} + {1'b0, thresh_q}));
        end
    endgenerate

    always_comb begin
        code = basic_bits;
        case (mode_q)
            LBP_MODE_BASIC:   code = basic_bits;
            LBP_MODE_THRESH:  code = thresh_bits;
            LBP_MODE_UNIFORM: code = uniform_code(basic_bits);
            LBP_MODE_RSVD:    code = basic_bits;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lbp_valid_q <= 1'b0;
            lbp_addr_q  <= '0;
            lbp_data_q  <= '0;
        end else begin
            lbp_valid_q <= accept && win_full;
            if (accept && win_full) begin
                lbp_addr_q <= addr_q - OUT_OFS;
                lbp_data_q <= code;
            end
        end
    end

    assign gray_addr = addr_q;
    assign gray_req  = (state_q == ST_FETCH);
    assign finish    = (state_q == ST_DONE);
    assign lbp_valid = lbp_valid_q;
    assign lbp_addr  = lbp_addr_q;
    assign lbp_data  = lbp_data_q;

endmodule

// File: tb/tb_lbp_stream_engine.sv
// Directed bench: a 128x128 engine for full-frame, reset and back-to-back runs,
// and a 5x4 engine for per-mode vectors and stalled frames against a golden model.
module tb_lbp_stream_engine;
    localparam int BW = 128;
    localparam int BH = 128;
    localparam int BA = 14;
    localparam int SW = 5;
    localparam int SH = 4;
    localparam int SA = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic [1:0]    mode;
    logic [7:0]    thresh;
    logic          start_b, start_s, ready_b, ready_s;
    logic [BA-1:0] b_gaddr, b_laddr;
    logic [SA-1:0] s_gaddr, s_laddr;
    logic [7:0]    b_gdata, s_gdata, b_ldata, s_ldata;
    logic          b_req, s_req, b_valid, s_valid, b_fin, s_fin;
    int            pat_b, pat_s;
    logic [7:0]    cval;

    int n_cmp = 0;
    int n_err = 0;

    int scnt[2], first_a[2], last_a[2], er[2], ec[2];
    int kind[2], expv[2], fmode[2], fthr[2], wid[2];

    // Test images: 0 constant, 1 horizontal gradient, 2 checkerboard, 3 hash.
    function automatic logic [7:0] pix(input int pat, input int r, input int c, input logic [7:0] cv);
        case (pat)
            0:       return cv;
            1:       return 8'(c);
            2:       return (((r + c) % 2) == 1) ? 8'd255 : 8'd0;
            default: return 8'((r * 37 + c * 101 + r * c * 13 + 29) % 256);
        endcase
    endfunction

    function automatic int ref_lbp(input int m, input int thr, input int pat, input int r, input int c);
        int dr[8];
        int dc[8];
        int b[8];
        int ring[8];
        int cen, n, code, ones, trans;
        dr[0] = -1; dc[0] = -1;
        dr[1] = -1; dc[1] = 0;
        dr[2] = -1; dc[2] = 1;
        dr[3] = 0;  dc[3] = -1;
        dr[4] = 0;  dc[4] = 1;
        dr[5] = 1;  dc[5] = -1;
        dr[6] = 1;  dc[6] = 0;
        dr[7] = 1;  dc[7] = 1;
        cen  = int'(pix(pat, r, c, cval));
        code = 0;
        ones = 0;
        for (int k = 0; k < 8; k++) begin
            n = int'(pix(pat, r + dr[k], c + dc[k], cval));
            if (m == 1) b[k] = (n >= cen + thr) ? 1 : 0;
            else        b[k] = (n >= cen) ? 1 : 0;
            code = code + (b[k] << k);
            ones = ones + b[k];
        end
        if (m != 2) return code;
        ring[0] = b[0]; ring[1] = b[1]; ring[2] = b[2]; ring[3] = b[4];
        ring[4] = b[7]; ring[5] = b[6]; ring[6] = b[5]; ring[7] = b[3];
        trans = 0;
        for (int i = 0; i < 8; i++) begin
            if (ring[i] != ring[(i + 1) % 8]) trans++;
        end
        return (trans <= 2) ? ones : 9;
    endfunction

    assign b_gdata = pix(pat_b, int'(b_gaddr) / BW, int'(b_gaddr) % BW, cval);
    assign s_gdata = pix(pat_s, int'(s_gaddr) / SW, int'(s_gaddr) % SW, cval);

    lbp_stream_engine #(.IMG_W(BW), .IMG_H(BH), .PIX_W(8), .ADDR_W(BA)) u_big (
        .clk(clk), .reset(reset), .start(start_b), .mode(mode), .lbp_thresh(thresh),
        .gray_ready(ready_b), .gray_data(b_gdata), .gray_addr(b_gaddr), .gray_req(b_req),
        .lbp_valid(b_valid), .lbp_addr(b_laddr), .lbp_data(b_ldata), .finish(b_fin)
    );

    lbp_stream_engine #(.IMG_W(SW), .IMG_H(SH), .PIX_W(8), .ADDR_W(SA)) u_small (
        .clk(clk), .reset(reset), .start(start_s), .mode(mode), .lbp_thresh(thresh),
        .gray_ready(ready_s), .gray_data(s_gdata), .gray_addr(s_gaddr), .gray_req(s_req),
        .lbp_valid(s_valid), .lbp_addr(s_laddr), .lbp_data(s_ldata), .finish(s_fin)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int fin_of(input int d);
        return (d == 0) ? int'(b_fin) : int'(s_fin);
    endfunction

    function automatic int req_of(input int d);
        return (d == 0) ? int'(b_req) : int'(s_req);
    endfunction

    task automatic on_strobe(input int d, input int addr, input int data);
        int pat;
        int expd;
        pat = (d == 0) ? pat_b : pat_s;
        case (kind[d])
            0:       expd = expv[d];
            1:       expd = (pix(pat, er[d], ec[d], cval) == 8'd255) ? 9 : 8;
            default: expd = ref_lbp(fmode[d], fthr[d], pat, er[d], ec[d]);
        endcase
        if (scnt[d] == 0) first_a[d] = addr;
        last_a[d] = addr;
        check($sformatf("dut%0d_addr_%0d", d, scnt[d]), addr, er[d] * wid[d] + ec[d]);
        check($sformatf("dut%0d_data_%0d", d, scnt[d]), data, expd);
        if (d == 1) $display("dut1 strobe %0d: addr=%0d data=%0d expected=%0d", scnt[d], addr, data, expd);
        scnt[d]++;
        ec[d]++;
        if (ec[d] == wid[d] - 1) begin
            ec[d] = 1;
            er[d]++;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (b_valid === 1'b1) on_strobe(0, int'(b_laddr), int'(b_ldata));
        if (s_valid === 1'b1) on_strobe(1, int'(s_laddr), int'(s_ldata));
    endtask

    // Start a frame; mode and threshold are disturbed afterwards to prove they were latched.
    task automatic begin_frame(input int d, input int m, input int t, input int pat, input int k, input int ev);
        scnt[d] = 0; first_a[d] = -1; last_a[d] = -1;
        er[d] = 1; ec[d] = 1;
        kind[d] = k; expv[d] = ev; fmode[d] = m; fthr[d] = t;
        mode   = 2'(m);
        thresh = 8'(t);
        if (d == 0) begin pat_b = pat; start_b = 1'b1; end
        else        begin pat_s = pat; start_s = 1'b1; end
        tick();
        start_b = 1'b0;
        start_s = 1'b0;
        mode    = mode + 2'd1;
        thresh  = thresh + 8'd77;
    endtask

    task automatic run_frame(input int d, input int budget, input bit rnd);
        for (int i = 0; i < budget; i++) begin
            if (fin_of(d) == 1) break;
            if (rnd) ready_s = 1'($urandom_range(0, 1));
            tick();
        end
        ready_s = 1'b1;
        check($sformatf("dut%0d_finish_reached", d), fin_of(d), 1);
    endtask

    task automatic end_frame(input int d, input int n, input int fa, input int la);
        check($sformatf("dut%0d_strobe_count", d), scnt[d], n);
        check($sformatf("dut%0d_first_addr", d), first_a[d], fa);
        check($sformatf("dut%0d_last_addr", d), last_a[d], la);
        tick();
        tick();
        check($sformatf("dut%0d_finish_held", d), fin_of(d), 1);
        check($sformatf("dut%0d_req_idle", d), req_of(d), 0);
        $display("dut%0d frame mode=%0d thresh=%0d pattern=%0d: %0d strobes", d, fmode[d], fthr[d],
                 (d == 0) ? pat_b : pat_s, scnt[d]);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gray_addr"}, int'(b_gaddr), 0);
        check({tag, "_gray_req"},  int'(b_req), 0);
        check({tag, "_lbp_valid"}, int'(b_valid), 0);
        check({tag, "_lbp_addr"},  int'(b_laddr), 0);
        check({tag, "_lbp_data"},  int'(b_ldata), 0);
        check({tag, "_finish"},    int'(b_fin), 0);
    endtask

    initial begin
        int held;
        wid[0] = BW; wid[1] = SW;
        for (int d = 0; d < 2; d++) begin
            scnt[d] = 0; first_a[d] = -1; last_a[d] = -1; er[d] = 1; ec[d] = 1;
            kind[d] = 0; expv[d] = 0; fmode[d] = 0; fthr[d] = 0;
        end
        reset = 1'b1; start_b = 1'b0; start_s = 1'b0; ready_b = 1'b1; ready_s = 1'b1;
        mode = 2'd0; thresh = 8'd0; pat_b = 0; pat_s = 0; cval = 8'd50;
        repeat (3) tick();
        check_reset_outputs("por");
        check("por_small_finish", int'(s_fin), 0);
        reset = 1'b0;
        tick();

        // Abort a frame part-way with reset.
        begin_frame(0, 0, 0, 0, 0, 255);
        repeat (400) tick();
        check("pre_reset_strobes_seen", (scnt[0] > 0) ? 1 : 0, 1);
        reset = 1'b1;
        tick();
        check_reset_outputs("midframe");
        reset = 1'b0;
        held = scnt[0];
        repeat (20) tick();
        check("post_reset_no_strobes", scnt[0], held);
        check("post_reset_no_req", int'(b_req), 0);

        // Full 128x128 constant frame, then an immediate restart in a new mode.
        begin_frame(0, 0, 0, 0, 0, 255);
        run_frame(0, 20000, 1'b0);
        end_frame(0, 15876, 129, 16254);
        begin_frame(0, 2, 0, 1, 0, 5);
        check("b2b_finish_dropped", int'(b_fin), 0);
        run_frame(0, 20000, 1'b0);
        end_frame(0, 15876, 129, 16254);

        // Directed per-mode vectors on the 5x4 engine.
        begin_frame(1, 0, 0, 1, 0, 8'hD6); run_frame(1, 200, 1'b0); end_frame(1, 6, 6, 13);
        begin_frame(1, 3, 0, 1, 0, 8'hD6); run_frame(1, 200, 1'b0); end_frame(1, 6, 6, 13);
        begin_frame(1, 2, 0, 1, 0, 5);     run_frame(1, 200, 1'b0); end_frame(1, 6, 6, 13);
        cval = 8'd50;
        begin_frame(1, 1, 1, 0, 0, 0);     run_frame(1, 200, 1'b0); end_frame(1, 6, 6, 13);
        cval = 8'd250;
        begin_frame(1, 1, 10, 0, 0, 0);    run_frame(1, 200, 1'b0); end_frame(1, 6, 6, 13);
        begin_frame(1, 1, 0, 0, 0, 255);   run_frame(1, 200, 1'b0); end_frame(1, 6, 6, 13);
        begin_frame(1, 2, 0, 2, 1, 0);     run_frame(1, 200, 1'b0); end_frame(1, 6, 6, 13);

        // Random gray_ready stalls against the golden model.
        begin_frame(1, 0, 0, 3, 2, 0);     run_frame(1, 400, 1'b1); end_frame(1, 6, 6, 13);
        begin_frame(1, 1, 20, 3, 2, 0);    run_frame(1, 400, 1'b1); end_frame(1, 6, 6, 13);
        begin_frame(1, 2, 0, 3, 2, 0);     run_frame(1, 400, 1'b1); end_frame(1, 6, 6, 13);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
